// File: rtl/peblock_seq.sv
// peblock_seq: tile sequencer that streams A/B operands into peblock, starts it, drains tempc to result memory, acks.
module peblock_seq #(
  parameter int NTILES = 4,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_a_addr,
  output logic [AW-1:0] mem_b_addr,
  input  logic [63:0]   mem_a_rdata,
  input  logic [63:0]   mem_b_rdata,
  output logic          pe_valid,
  output logic [2:0]    pe_addra,
  output logic [2:0]    pe_addrb,
  output logic [63:0]   pe_inpa,
  output logic [63:0]   pe_inpb,
  output logic          pe_start,
  output logic          pe_tempc_ack,
  input  logic [7:0]    pe_pedone,
  input  logic [1023:0] pe_tempc,
  output logic          res_we,
  output logic [AW-1:0] res_addr,
  output logic [127:0]  res_wdata
);
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DRAIN, ACK, RELEASE} state_t;
  localparam int TW = AW - 3;
  state_t state_q, state_d;
  logic [TW-1:0] tile_q, tile_d;
  logic [3:0] idx_q, idx_d;
  logic [2:0] k_q, k_d;
  logic busy_q, busy_d, done_q, done_d;
  logic pe_valid_q, pe_valid_d, pe_start_q, pe_start_d, pe_ack_q, pe_ack_d, res_we_q, res_we_d;
  logic [2:0] pe_addr_q, pe_addr_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d, res_addr_q, res_addr_d;
  logic [127:0] res_wdata_q, res_wdata_d;
  assign busy = busy_q;
  assign done = done_q;
  assign mem_a_addr = mem_addr_q;
  assign mem_b_addr = mem_addr_q;
  assign pe_valid = pe_valid_q;
  assign pe_addra = pe_addr_q;
  assign pe_addrb = pe_addr_q;
  assign pe_inpa = mem_a_rdata;
  assign pe_inpb = mem_b_rdata;
  assign pe_start = pe_start_q;
  assign pe_tempc_ack = pe_ack_q;
  assign res_we = res_we_q;
  assign res_addr = res_addr_q;
  assign res_wdata = res_wdata_q;
  always_comb begin
    state_d = state_q;
    tile_d = tile_q;
    idx_d = idx_q;
    k_d = k_q;
    busy_d = state_q != IDLE;
    done_d = 1'b0;
    pe_valid_d = 1'b0;
    pe_addr_d = pe_addr_q;
    pe_start_d = 1'b0;
    pe_ack_d = 1'b0;
    res_we_d = 1'b0;
    res_addr_d = res_addr_q;
    res_wdata_d = res_wdata_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      IDLE: if (go) begin
        state_d = LOAD;
        tile_d = '0;
        idx_d = '0;
      end
      LOAD: begin
        mem_addr_d = idx_q[3] ? mem_addr_q : {tile_q, idx_q[2:0]};
        pe_valid_d = idx_q != 4'd0;
        pe_addr_d = idx_q[2:0] - 3'd1;
        idx_d = idx_q + 4'd1;
        state_d = idx_q[3] ? START : LOAD;
      end
      START: begin
        pe_start_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: if (pe_pedone == 8'hff) begin
        state_d = DRAIN;
        k_d = '0;
      end
      DRAIN: begin
        res_we_d = 1'b1;
        res_addr_d = {tile_q, k_q};
        res_wdata_d = pe_tempc[{k_q, 7'd0} +: 128];
        k_d = k_q + 3'd1;
        state_d = k_q == 3'd7 ? ACK : DRAIN;
      end
      ACK: begin
        pe_ack_d = 1'b1;
        state_d = RELEASE;
      end
      RELEASE: if (pe_pedone == 8'h00) begin
        done_d = tile_q == TW'(NTILES - 1);
        busy_d = !done_d;
        state_d = done_d ? IDLE : LOAD;
        tile_d = done_d ? tile_q : tile_q + 1'b1;
        idx_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tile_q <= '0;
      idx_q <= '0;
      k_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pe_valid_q <= 1'b0;
      pe_addr_q <= '0;
      pe_start_q <= 1'b0;
      pe_ack_q <= 1'b0;
      res_we_q <= 1'b0;
      res_addr_q <= '0;
      res_wdata_q <= '0;
      mem_addr_q <= '0;
    end else begin
      state_q <= state_d;
      tile_q <= tile_d;
      idx_q <= idx_d;
      k_q <= k_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pe_valid_q <= pe_valid_d;
      pe_addr_q <= pe_addr_d;
      pe_start_q <= pe_start_d;
      pe_ack_q <= pe_ack_d;
      res_we_q <= res_we_d;
      res_addr_q <= res_addr_d;
      res_wdata_q <= res_wdata_d;
      mem_addr_q <= mem_addr_d;
    end
  end
endmodule

// File: tb/tb_peblock_seq.sv
// tb_peblock_seq: randomized directed bench for peblock_seq with memory, array and scoreboard models.
module tb_peblock_seq;
  localparam int NT = 4;
  localparam int AW = 8;
  logic clk = 1'b0, rst = 1'b1, go = 1'b0;
  logic busy, done, pe_valid, pe_start, pe_tempc_ack, res_we;
  logic [AW-1:0] mem_a_addr, mem_b_addr, res_addr;
  logic [63:0] mem_a_rdata = '0, mem_b_rdata = '0, pe_inpa, pe_inpb;
  logic [2:0] pe_addra, pe_addrb;
  logic [7:0] pe_pedone = '0;
  logic [1023:0] pe_tempc = '0;
  logic [127:0] res_wdata;
  logic [63:0] mem_a [256];
  logic [63:0] mem_b [256];
  logic [63:0] opa [8];
  logic [63:0] opb [8];
  int total = 0, bad = 0;
  int cdelay = 20, partial = 0, rel = 0, cd = 0, ph = 0, rc = 0;
  int cyc = 0, start_cnt, ack_cnt, done_cnt, excl, gap, order_err, we_part, valid_busy, ff_cyc, we_cyc, running;
  logic [7:0] prev_pd = '0;
  logic [2:0] b_addr [$];
  logic [2:0] b_addrb [$];
  logic [63:0] b_a [$];
  logic [63:0] b_b [$];
  logic [AW-1:0] w_addr [$];
  logic [127:0] w_data [$];

  peblock_seq #(.NTILES(NT), .AW(AW)) dut (
    .clk(clk), .rst(rst), .go(go), .busy(busy), .done(done),
    .mem_a_addr(mem_a_addr), .mem_b_addr(mem_b_addr),
    .mem_a_rdata(mem_a_rdata), .mem_b_rdata(mem_b_rdata),
    .pe_valid(pe_valid), .pe_addra(pe_addra), .pe_addrb(pe_addrb),
    .pe_inpa(pe_inpa), .pe_inpb(pe_inpb), .pe_start(pe_start),
    .pe_tempc_ack(pe_tempc_ack), .pe_pedone(pe_pedone), .pe_tempc(pe_tempc),
    .res_we(res_we), .res_addr(res_addr), .res_wdata(res_wdata)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    mem_a_rdata <= mem_a[mem_a_addr];
    mem_b_rdata <= mem_b[mem_b_addr];
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      pe_pedone = '0;
      cd = 0;
      ph = 0;
      rc = 0;
    end else begin
      if (pe_valid) begin
        opa[pe_addra] = pe_inpa;
        opb[pe_addrb] = pe_inpb;
      end
      if (pe_start) begin
        for (int j = 0; j < 8; j++) pe_tempc[j*128 +: 128] = 128'(opa[j]) * 128'(opb[j]);
        cd = cdelay;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          pe_pedone = partial != 0 ? 8'h7f : 8'hff;
          ph = partial != 0 ? 50 : 0;
        end
      end else if (ph > 0) begin
        ph--;
        if (ph == 0) pe_pedone = 8'hff;
      end
      if (pe_tempc_ack) begin
        rc = rel;
        if (rel == 0) pe_pedone = '0;
      end else if (rc > 0) begin
        rc--;
        if (rc == 0) pe_pedone = '0;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (int'(pe_valid) + int'(pe_start) + int'(pe_tempc_ack) + int'(res_we) > 1) excl++;
    if (pe_valid) begin
      b_addr.push_back(pe_addra);
      b_addrb.push_back(pe_addrb);
      b_a.push_back(pe_inpa);
      b_b.push_back(pe_inpb);
      if (pe_pedone != 8'h00) valid_busy++;
    end
    if (pe_start) begin
      if (b_addr.size() != 8 * (start_cnt + 1)) order_err++;
      start_cnt++;
    end
    if (res_we) begin
      w_addr.push_back(res_addr);
      w_data.push_back(res_wdata);
      if (pe_pedone == 8'h7f) we_part++;
      if (we_cyc < 0) we_cyc = cyc;
    end
    if (pe_tempc_ack) begin
      if (w_addr.size() != 8 * (ack_cnt + 1)) order_err++;
      ack_cnt++;
    end
    if (pe_pedone == 8'hff && prev_pd != 8'hff && ff_cyc < 0) ff_cyc = cyc;
    prev_pd = pe_pedone;
    if (done) begin
      done_cnt++;
      running = 0;
      if (ack_cnt != NT) order_err++;
    end else if (running != 0 && !busy) gap++;
    else if (busy) running = 1;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 128'(busy), 0);
    chk({tag, "_done"}, 128'(done), 0);
    chk({tag, "_valid"}, 128'(pe_valid), 0);
    chk({tag, "_addra"}, 128'(pe_addra), 0);
    chk({tag, "_addrb"}, 128'(pe_addrb), 0);
    chk({tag, "_start"}, 128'(pe_start), 0);
    chk({tag, "_ack"}, 128'(pe_tempc_ack), 0);
    chk({tag, "_we"}, 128'(res_we), 0);
    chk({tag, "_raddr"}, 128'(res_addr), 0);
    chk({tag, "_wdata"}, res_wdata, 0);
    chk({tag, "_maddra"}, 128'(mem_a_addr), 0);
    chk({tag, "_maddrb"}, 128'(mem_b_addr), 0);
  endtask

  task automatic prep(input int c, input int p, input int r);
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = {$urandom, $urandom};
      mem_b[i] = {$urandom, $urandom};
    end
    b_addr.delete(); b_addrb.delete(); b_a.delete(); b_b.delete();
    w_addr.delete(); w_data.delete();
    start_cnt = 0; ack_cnt = 0; done_cnt = 0; excl = 0; gap = 0; order_err = 0;
    we_part = 0; valid_busy = 0; ff_cyc = -1; we_cyc = -1; running = 0;
    cdelay = c; partial = p; rel = r;
  endtask

  task automatic run(input string tag, input int c, input int p, input int r, input int g);
    prep(c, p, r);
    go = 1'b1;
    tick();
    go = 1'b0;
    chk({tag, "_lat_busy0"}, 128'(busy), 0);
    tick();
    chk({tag, "_lat_busy1"}, 128'(busy), 1);
    chk({tag, "_lat_addr"}, 128'(mem_a_addr), 0);
    chk({tag, "_lat_valid1"}, 128'(pe_valid), 0);
    tick();
    chk({tag, "_lat_valid2"}, 128'(pe_valid), 1);
    if (g != 0) begin
      for (int i = 0; i < 200 && start_cnt == 0; i++) tick();
      repeat (3) tick();
      go = 1'b1;
      tick();
      go = 1'b0;
    end
    for (int i = 0; i < 5000 && done_cnt == 0; i++) tick();
    chk({tag, "_finished"}, 128'(done_cnt != 0), 1);
    repeat (5) tick();
    chk({tag, "_beats"}, 128'(b_addr.size()), 8 * NT);
    for (int i = 0; i < b_addr.size() && i < 8 * NT; i++) begin
      chk($sformatf("%s_va%0d", tag, i), 128'(b_addr[i]), 128'(i % 8));
      chk($sformatf("%s_vb%0d", tag, i), 128'(b_addrb[i]), 128'(i % 8));
      chk($sformatf("%s_da%0d", tag, i), 128'(b_a[i]), 128'(mem_a[i]));
      chk($sformatf("%s_db%0d", tag, i), 128'(b_b[i]), 128'(mem_b[i]));
    end
    chk({tag, "_writes"}, 128'(w_addr.size()), 8 * NT);
    for (int i = 0; i < w_addr.size() && i < 8 * NT; i++) begin
      chk($sformatf("%s_wa%0d", tag, i), 128'(w_addr[i]), 128'(i));
      chk($sformatf("%s_wd%0d", tag, i), w_data[i], 128'(mem_a[i]) * 128'(mem_b[i]));
    end
    chk({tag, "_starts"}, 128'(start_cnt), NT);
    chk({tag, "_acks"}, 128'(ack_cnt), NT);
    chk({tag, "_dones"}, 128'(done_cnt), 1);
    chk({tag, "_excl"}, 128'(excl), 0);
    chk({tag, "_busy_gap"}, 128'(gap), 0);
    chk({tag, "_order"}, 128'(order_err), 0);
    chk({tag, "_we_partial"}, 128'(we_part), 0);
    chk({tag, "_valid_stale"}, 128'(valid_busy), 0);
    chk({tag, "_drain_lat"}, 128'(we_cyc - ff_cyc), 1);
    chk({tag, "_idle_busy"}, 128'(busy), 0);
  endtask

  initial begin
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();
    run("multi", 20, 0, 0, 0);
    run("partial", 5, 1, 0, 0);
    run("slowrel_go", 20, 0, 5, 1);
    prep(20, 0, 0);
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 500 && w_addr.size() < 3; i++) tick();
    chk("rm_reached", 128'(w_addr.size()), 3);
    rst = 1'b1;
    tick();
    chk_zero("rm");
    rst = 1'b0;
    repeat (3) tick();
    chk("rm_no_done", 128'(done_cnt), 0);
    run("after_rst", 3, 0, 2, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
